// File: rtl/pwl_act_pipe.sv
// pwl_act_pipe: three-stage, multi-lane piecewise-linear activation unit.
// Lane math: S1 forms x+ONE / x-ONE, S2 takes magnitudes, S3 combines per mode
// and narrows to WIDTH bits. Define PWL_SAT_EN to clamp the result, raise the
// per-lane out_sat_o flags and build the saturation-event counter; without it
// the result wraps and out_sat_o / sat_cnt_o are tied to zero.
module pwl_act_pipe #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned LANES = 4,
    parameter int unsigned FRAC  = 0,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [1:0]               in_mode_i,
    input  logic [LANES*2*WIDTH-1:0] in_data_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [LANES*WIDTH-1:0]   out_data_o,
    output logic [LANES-1:0]         out_sat_o,
    output logic [CNT_W-1:0]         sat_cnt_o,
    input  logic                     sat_clr_i
);

    localparam int unsigned InW = 2 * WIDTH;
    localparam int unsigned XW  = InW + 1;  // x +/- ONE never wraps at this width
    localparam int unsigned SW  = InW + 2;  // |xp| + |xm| never wraps at this width

    localparam logic [XW-1:0]        One    = XW'(1) << FRAC;
    localparam logic [XW-1:0]        XInc   = XW'(1);
    localparam logic signed [SW-1:0] SatMax = SW'((1 << (WIDTH - 1)) - 1);
    localparam logic signed [SW-1:0] SatMin = SW'(-(1 << (WIDTH - 1)));

    logic                            adv;

    logic                            s1_valid_q;
    logic [1:0]                      s1_mode_q;
    logic [LANES-1:0][InW-1:0]       s1_x_q;
    logic [LANES-1:0][XW-1:0]        s1_xp_q, s1_xm_q, s1_xp_d, s1_xm_d;

    logic                            s2_valid_q;
    logic [1:0]                      s2_mode_q;
    logic [LANES-1:0][InW-1:0]       s2_x_q;
    logic [LANES-1:0][XW-1:0]        s2_ap_q, s2_am_q, s2_ap_d, s2_am_d;

    logic [LANES-1:0][SW-1:0]        s3_r;
    logic                            out_valid_q;
    logic [LANES-1:0][WIDTH-1:0]     out_data_q, out_data_d;

    // Single global stall: everything moves unless a held output is refused.
    assign adv         = !out_valid_q || out_ready_i;
    assign in_ready_o  = adv;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;

    // S1 next-state: sign-extend each lane and form x+ONE and x-ONE.
    always_comb begin
        s1_xp_d = '0;
        s1_xm_d = '0;
        for (int k = 0; k < LANES; k++) begin
            s1_xp_d[k] = {in_data_i[k*InW+InW-1], in_data_i[k*InW +: InW]} + One;
            s1_xm_d[k] = {in_data_i[k*InW+InW-1], in_data_i[k*InW +: InW]} - One;
        end
    end

    // S2 next-state: magnitudes of the two offset terms.
    always_comb begin
        s2_ap_d = '0;
        s2_am_d = '0;
        for (int k = 0; k < LANES; k++) begin
            s2_ap_d[k] = s1_xp_q[k][XW-1] ? (~s1_xp_q[k] + XInc) : s1_xp_q[k];
            s2_am_d[k] = s1_xm_q[k][XW-1] ? (~s1_xm_q[k] + XInc) : s1_xm_q[k];
        end
    end

    // S3 combine: per-mode result at full width, before narrowing.
    always_comb begin
        logic signed [SW-1:0] sum;
        logic signed [SW-1:0] diff;
        logic signed [SW-1:0] xs;
        sum  = '0;
        diff = '0;
        xs   = '0;
        s3_r = '0;
        for (int k = 0; k < LANES; k++) begin
            sum  = {1'b0, s2_ap_q[k]} + {1'b0, s2_am_q[k]};
            diff = {1'b0, s2_ap_q[k]} - {1'b0, s2_am_q[k]};
            xs   = {{2{s2_x_q[k][InW-1]}}, s2_x_q[k]};
            unique case (s2_mode_q)
                2'd0:    s3_r[k] = sum >>> 1;
                2'd1:    s3_r[k] = diff >>> 1;
                2'd2:    s3_r[k] = xs[SW-1] ? '0 : xs;
                default: s3_r[k] = xs;
            endcase
        end
    end

`ifdef PWL_SAT_EN
    logic [LANES-1:0] out_sat_q, out_sat_d;
    logic [CNT_W-1:0] sat_cnt_q, sat_cnt_d;

    assign out_sat_o = out_sat_q;
    assign sat_cnt_o = sat_cnt_q;

    // Narrow with clamping; flag every lane that was clamped.
    always_comb begin
        out_data_d = '0;
        out_sat_d  = '0;
        for (int k = 0; k < LANES; k++) begin
            if ($signed(s3_r[k]) > SatMax) begin
                out_data_d[k] = SatMax[WIDTH-1:0];
                out_sat_d[k]  = 1'b1;
            end else if ($signed(s3_r[k]) < SatMin) begin
                out_data_d[k] = SatMin[WIDTH-1:0];
                out_sat_d[k]  = 1'b1;
            end else begin
                out_data_d[k] = s3_r[k][WIDTH-1:0];
            end
        end
    end

    // Saturation flags travel with the output stage.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_sat_q <= '0;
        end else if (adv) begin
            out_sat_q <= out_sat_d;
        end
    end

    // Count transferred beats with any clamped lane; clear wins, no wrap.
    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (sat_clr_i) begin
            sat_cnt_d = '0;
        end else if (out_valid_q && out_ready_i && (|out_sat_q) && (sat_cnt_q != '1)) begin
            sat_cnt_d = sat_cnt_q + CNT_W'(1);
        end
    end

    // Saturation counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sat_cnt_q <= '0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
        end
    end
`else
    logic unused_sat_clr;
    logic unused_s3_hi;

    assign out_sat_o      = '0;
    assign sat_cnt_o      = '0;
    assign unused_sat_clr = sat_clr_i;
    assign unused_s3_hi   = ^s3_r;

    // Narrow by two's-complement truncation.
    always_comb begin
        out_data_d = '0;
        for (int k = 0; k < LANES; k++) begin
            out_data_d[k] = s3_r[k][WIDTH-1:0];
        end
    end
`endif

    // Pipeline registers: all stages shift together on adv.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid_q  <= 1'b0;
            s1_mode_q   <= '0;
            s1_x_q      <= '0;
            s1_xp_q     <= '0;
            s1_xm_q     <= '0;
            s2_valid_q  <= 1'b0;
            s2_mode_q   <= '0;
            s2_x_q      <= '0;
            s2_ap_q     <= '0;
            s2_am_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (adv) begin
            s1_valid_q  <= in_valid_i;
            s1_mode_q   <= in_mode_i;
            s1_x_q      <= in_data_i;
            s1_xp_q     <= s1_xp_d;
            s1_xm_q     <= s1_xm_d;
            s2_valid_q  <= s1_valid_q;
            s2_mode_q   <= s1_mode_q;
            s2_x_q      <= s1_x_q;
            s2_ap_q     <= s2_ap_d;
            s2_am_q     <= s2_am_d;
            out_valid_q <= s2_valid_q;
            out_data_q  <= out_data_d;
        end
    end

endmodule

// File: tb/tb_pwl_act_pipe.sv
// Self-checking bench for pwl_act_pipe (WIDTH=9, LANES=4, FRAC=0, plus a FRAC=4
// instance). Expected beats come from a directed table or an integer model of
// the activation functions and are matched in order by a negedge monitor.
module tb_pwl_act_pipe;

    typedef struct packed {
        logic [35:0] d;
        logic [3:0]  s;
    } exp_t;

    typedef struct packed {
        logic [1:0]  mode;
        logic [71:0] x;
        logic [35:0] y;
        logic [3:0]  s;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_mode = '0;
    logic [71:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [35:0] out_data;
    logic [3:0]  out_sat;
    logic [15:0] sat_cnt;
    logic        sat_clr = 1'b0;

    logic        f_in_valid = 1'b0;
    logic        f_in_ready;
    logic [1:0]  f_in_mode = '0;
    logic [71:0] f_in_data = '0;
    logic        f_out_valid;
    logic [35:0] f_out_data;
    logic [3:0]  f_out_sat;
    logic [15:0] f_sat_cnt;

    int          checks = 0;
    int          errors = 0;
    int          beat_n = 0;
    int          cyc    = 0;
    bit          rdy_pat = 1'b0;
    logic [15:0] exp_cnt = '0;
    bit          prev_stall = 1'b0;
    exp_t        q[$];

    pwl_act_pipe #(.WIDTH(9), .LANES(4), .FRAC(0), .CNT_W(16)) u_dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_mode_i  (in_mode),
        .in_data_i  (in_data),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (out_data),
        .out_sat_o  (out_sat),
        .sat_cnt_o  (sat_cnt),
        .sat_clr_i  (sat_clr)
    );

    pwl_act_pipe #(.WIDTH(9), .LANES(4), .FRAC(4), .CNT_W(16)) u_dut_f (
        .clk_i      (clk),
        .rst_i      (rst),
        .in_valid_i (f_in_valid),
        .in_ready_o (f_in_ready),
        .in_mode_i  (f_in_mode),
        .in_data_i  (f_in_data),
        .out_valid_o(f_out_valid),
        .out_ready_i(1'b1),
        .out_data_o (f_out_data),
        .out_sat_o  (f_out_sat),
        .sat_cnt_o  (f_sat_cnt),
        .sat_clr_i  (1'b0)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired got timeout exp finish");
        $fatal(1);
    end

    task automatic check_val(input string name, input logic [63:0] got,
                             input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on one lane.
    function automatic void model_lane(input int x, input int m, input int frac,
                                       output logic [8:0] y, output logic s);
        int one, ap, am, r;
        one = 1 << frac;
        ap  = x + one;
        am  = x - one;
        if (ap < 0) ap = -ap;
        if (am < 0) am = -am;
        case (m)
            0:       r = (ap + am) >>> 1;
            1:       r = (ap - am) >>> 1;
            2:       r = (x < 0) ? 0 : x;
            default: r = x;
        endcase
        s = 1'b0;
`ifdef PWL_SAT_EN
        if (r > 255) begin
            r = 255;
            s = 1'b1;
        end else if (r < -256) begin
            r = -256;
            s = 1'b1;
        end
`endif
        y = r[8:0];
    endfunction

    function automatic exp_t mk_exp(input int m, input int frac, input int x0,
                                    input int x1, input int x2, input int x3);
        int         xs[4];
        exp_t       e;
        logic [8:0] y;
        logic       s;
        xs = '{x0, x1, x2, x3};
        e  = '0;
        for (int k = 0; k < 4; k++) begin
            model_lane(xs[k], m, frac, y, s);
            e.d[k*9 +: 9] = y;
            e.s[k]        = s;
        end
        return e;
    endfunction

    function automatic logic [71:0] pack_x(input int x0, input int x1, input int x2,
                                           input int x3);
        return {x3[17:0], x2[17:0], x1[17:0], x0[17:0]};
    endfunction

    function automatic logic [35:0] pack_y(input int y0, input int y1, input int y2,
                                           input int y3);
        return {y3[8:0], y2[8:0], y1[8:0], y0[8:0]};
    endfunction

    function automatic int rnd_x();
        logic signed [17:0] t;
        int                 r;
        case ($urandom_range(0, 3))
            0: r = int'($urandom_range(0, 600)) - 300;
            1: begin
                t = 18'($urandom);
                r = t;
            end
            2: r = ($urandom_range(0, 1) == 0) ? -131072 : 131071;
            default: r = int'($urandom_range(0, 6)) - 3;
        endcase
        return r;
    endfunction

    // Downstream readiness: always ready, or low one cycle in three.
    always @(posedge clk) begin
        #1;
        cyc++;
        out_ready = rdy_pat ? ((cyc % 3) != 2) : 1'b1;
    end

    // Output monitor: in-order scoreboard, stall stability and sat_cnt model.
    always @(negedge clk) begin
        exp_t e;
        bit   xfer;
        bit   xsat;
        if (rst) begin
            exp_cnt    = '0;
            prev_stall = 1'b0;
        end else begin
            check_val("sat_cnt", 64'(sat_cnt), 64'(exp_cnt));
            if (prev_stall) begin
                check_val("stall_valid", 64'(out_valid), 64'(1));
                if (q.size() != 0) begin
                    check_val("stall_data", 64'(out_data), 64'(q[0].d));
                    check_val("stall_sat", 64'(out_sat), 64'(q[0].s));
                end
            end
            xfer = out_valid && out_ready;
            xsat = 1'b0;
            if (xfer) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat got %h exp none", out_data);
                end else begin
                    e = q.pop_front();
                    beat_n++;
                    check_val($sformatf("data beat %0d", beat_n), 64'(out_data), 64'(e.d));
                    check_val($sformatf("sat beat %0d", beat_n), 64'(out_sat), 64'(e.s));
                    xsat = |e.s;
                end
            end
            prev_stall = out_valid && !out_ready;
            if (sat_clr) exp_cnt = '0;
            else if (xfer && xsat && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        end
    end

    // Present one beat (entered #1 after a posedge) and wait until accepted.
    task automatic send_beat(input logic [1:0] m, input logic [71:0] d, input exp_t e);
        bit acc;
        bit got;
        in_valid = 1'b1;
        in_mode  = m;
        in_data  = d;
        got      = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout got 0 exp 1");
        end else begin
            q.push_back(e);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
        check_val("drain", 64'(q.size()), 64'(0));
        q.delete();
        @(posedge clk);
        #1;
    endtask

    vec_t vt[6];

    initial begin
        int   n;
        int   m;
        int   x0, x1, x2, x3;
        exp_t e;

        vt[0] = '{mode: 2'd0, x: pack_x(5, 0, -7, 1), y: pack_y(5, 1, 7, 1), s: 4'b0000};
        vt[1] = '{mode: 2'd1, x: pack_x(5, -5, 0, 200), y: pack_y(1, -1, 0, 1), s: 4'b0000};
        vt[2] = '{mode: 2'd2, x: pack_x(-3, 3, 0, -256), y: pack_y(0, 3, 0, 0), s: 4'b0000};
`ifdef PWL_SAT_EN
        vt[3] = '{mode: 2'd3, x: pack_x(300, -300, 255, -256),
                  y: pack_y(255, -256, 255, -256), s: 4'b0011};
        vt[4] = '{mode: 2'd0, x: pack_x(-131072, 0, 0, 0), y: pack_y(255, 1, 1, 1),
                  s: 4'b0001};
`else
        vt[3] = '{mode: 2'd3, x: pack_x(300, -300, 255, -256),
                  y: pack_y(-212, 212, 255, -256), s: 4'b0000};
        vt[4] = '{mode: 2'd0, x: pack_x(-131072, 0, 0, 0), y: pack_y(0, 1, 1, 1),
                  s: 4'b0000};
`endif
        vt[5] = '{mode: 2'd1, x: pack_x(-131072, 131071, -1, 2), y: pack_y(-1, 1, -1, 1),
                  s: 4'b0000};

        // Reset values.
        #1 rst = 1'b1;
        #1;
        check_val("rst out_valid", 64'(out_valid), 64'(0));
        check_val("rst out_data", 64'(out_data), 64'(0));
        check_val("rst out_sat", 64'(out_sat), 64'(0));
        check_val("rst sat_cnt", 64'(sat_cnt), 64'(0));
        check_val("rst in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1 rst = 1'b0;

        // Directed table, one beat at a time.
        for (int i = 0; i < 6; i++) begin
            e.d = vt[i].y;
            e.s = vt[i].s;
            send_beat(vt[i].mode, vt[i].x, e);
            in_valid = 1'b0;
            if (i == 0) begin
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!out_valid && n < 10);
                check_val("latency", 64'(n), 64'(3));
                @(posedge clk);
                #1;
            end
            drain();
        end

        // Saturating beat transferred while sat_clr is held: clear wins.
        sat_clr = 1'b1;
        e.d = vt[3].y;
        e.s = vt[3].s;
        send_beat(vt[3].mode, vt[3].x, e);
        in_valid = 1'b0;
        drain();
        sat_clr = 1'b0;
        check_val("sat_cnt after clr", 64'(sat_cnt), 64'(0));

        // Random stream under 1-in-3 backpressure; first ten beats cycle modes.
        rdy_pat = 1'b1;
        for (int i = 0; i < 40; i++) begin
            m  = (i < 10) ? (i % 4) : int'($urandom_range(0, 3));
            x0 = rnd_x();
            x1 = rnd_x();
            x2 = rnd_x();
            x3 = rnd_x();
            send_beat(2'(m), pack_x(x0, x1, x2, x3), mk_exp(m, 0, x0, x1, x2, x3));
        end
        in_valid = 1'b0;
        drain();
        rdy_pat = 1'b0;
        @(posedge clk);
        #1;

        // Reset with three saturating beats in flight.
        for (int i = 0; i < 3; i++) begin
            send_beat(2'd3, pack_x(300, -300, 1000, -1000),
                      mk_exp(3, 0, 300, -300, 1000, -1000));
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        check_val("midrst out_valid", 64'(out_valid), 64'(0));
        check_val("midrst sat_cnt", 64'(sat_cnt), 64'(0));
        q.delete();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check_val("midrst in_ready", 64'(in_ready), 64'(1));
        for (int i = 0; i < 10; i++) @(negedge clk);
        @(posedge clk);
        #1;
        send_beat(2'd2, pack_x(-9, 9, 100, -1), mk_exp(2, 0, -9, 9, 100, -1));
        in_valid = 1'b0;
        drain();

        // FRAC=4 instance, hard-tanh with ONE=16.
        f_in_valid = 1'b1;
        f_in_mode  = 2'd1;
        f_in_data  = pack_x(8, 40, -8, -40);
        @(posedge clk);
        #1 f_in_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!f_out_valid && n < 10);
        check_val("frac latency", 64'(n), 64'(3));
        check_val("frac data", 64'(f_out_data), 64'(pack_y(8, 16, -8, -16)));
        check_val("frac sat", 64'(f_out_sat), 64'(0));

        @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
